// File: rtl/multi_toggle_fsm.sv
// Bank of CH independent toggle/counter lanes sharing one mode and enable.
// Each lane tracks a parity bit, its complement, a CW-bit counter and a terminal-count pulse.
module multi_toggle_fsm #(
  parameter int CH   = 4,
  parameter int CW   = 3,
  parameter int EDGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CH-1:0]    in,
  input  logic [CH-1:0]    clr,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    outn,
  output logic [CH*CW-1:0] cnt,
  output logic [CH-1:0]    tc
);

  typedef enum logic [1:0] {
    MODE_TOGGLE     = 2'b00,
    MODE_TOGGLE_INV = 2'b01,
    MODE_COUNT_UP   = 2'b10,
    MODE_COUNT_DOWN = 2'b11
  } mode_t;

  logic [CH-1:0]    r_out;
  logic [CH-1:0]    r_outn;
  logic [CH*CW-1:0] r_cnt;
  logic [CH-1:0]    r_tc;
  logic [CH-1:0]    r_in_q;

  logic [CH-1:0]    w_ev;
  logic [CH-1:0]    w_out_nxt;
  logic [CH-1:0]    w_outn_nxt;
  logic [CH*CW-1:0] w_cnt_nxt;
  logic [CH-1:0]    w_tc_nxt;
  mode_t            w_mode;

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    return v + 1'b1;
  endfunction

  // Down-count stops at zero instead of wrapping.
  function automatic logic [CW-1:0] cnt_dec_sat(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign w_mode = mode_t'(mode);
  assign w_ev   = (EDGE != 0) ? (in & ~r_in_q) : in;

  always_comb begin
    w_out_nxt  = r_out;
    w_outn_nxt = r_outn;
    w_cnt_nxt  = r_cnt;
    w_tc_nxt   = '0;
    for (int i = 0; i < CH; i++) begin
      if (clr[i]) begin
        w_out_nxt[i]           = 1'b0;
        w_outn_nxt[i]          = 1'b1;
        w_cnt_nxt[i*CW +: CW]  = '0;
      end else if (en) begin
        unique case (w_mode)
          MODE_TOGGLE: begin
            w_out_nxt[i]  = w_ev[i] ^ r_out[i];
            w_outn_nxt[i] = ~(w_ev[i] ^ r_out[i]);
          end
          MODE_TOGGLE_INV: begin
            w_out_nxt[i]  = ~w_ev[i] ^ r_out[i];
            w_outn_nxt[i] = ~(~w_ev[i] ^ r_out[i]);
          end
          MODE_COUNT_UP: begin
            if (w_ev[i]) begin
              w_cnt_nxt[i*CW +: CW] = cnt_inc(r_cnt[i*CW +: CW]);
              w_tc_nxt[i]           = &r_cnt[i*CW +: CW];
            end
            w_out_nxt[i]  = w_cnt_nxt[i*CW];
            w_outn_nxt[i] = ~w_cnt_nxt[i*CW];
          end
          MODE_COUNT_DOWN: begin
            if (w_ev[i]) begin
              w_cnt_nxt[i*CW +: CW] = cnt_dec_sat(r_cnt[i*CW +: CW]);
              w_tc_nxt[i]           = (r_cnt[i*CW +: CW] == CW'(1));
            end
            w_out_nxt[i]  = w_cnt_nxt[i*CW];
            w_outn_nxt[i] = ~w_cnt_nxt[i*CW];
          end
        endcase
      end
    end
  end

  // Register stage: every output and the edge history update here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_outn <= '0;
      r_cnt  <= '0;
      r_tc   <= '0;
      r_in_q <= '0;
    end else begin
      r_in_q <= in;
      r_out  <= w_out_nxt;
      r_outn <= w_outn_nxt;
      r_cnt  <= w_cnt_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign out  = r_out;
  assign outn = r_outn;
  assign cnt  = r_cnt;
  assign tc   = r_tc;

endmodule

// File: tb/tb_multi_toggle_fsm.sv
// Bench for multi_toggle_fsm: level- and edge-event instances driven in parallel,
// checked against directed vectors, corner sequences and a behavioural model.
module tb_multi_toggle_fsm;
  localparam int CH = 4;
  localparam int CW = 3;
  localparam int M  = 1 << CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en;
  logic [1:0]       mode;
  logic [CH-1:0]    in_v, clr;
  logic [CH-1:0]    out0, outn0, tc0, out1, outn1, tc1;
  logic [CH*CW-1:0] cnt0, cnt1;

  multi_toggle_fsm #(.CH(CH), .CW(CW), .EDGE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_v), .clr(clr),
    .out(out0), .outn(outn0), .cnt(cnt0), .tc(tc0));

  multi_toggle_fsm #(.CH(CH), .CW(CW), .EDGE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in_v), .clr(clr),
    .out(out1), .outn(outn1), .cnt(cnt1), .tc(tc1));

  int total = 0;
  int bad   = 0;

  // Model state per instance (0 = level events, 1 = rising-edge events).
  int m_cnt  [2][CH];
  bit m_out  [2][CH];
  bit m_outn [2][CH];
  bit m_tc   [2][CH];
  bit m_inq  [2][CH];

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  in;
    logic [3:0]  clr;
    logic [3:0]  e_out;
    logic [3:0]  e_outn;
    logic [11:0] e_cnt;
    logic [3:0]  e_tc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic e, logic [1:0] md, logic [3:0] iv, logic [3:0] c,
                              logic [3:0] eo, logic [3:0] eon, logic [11:0] ec, logic [3:0] et);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.in = iv; v.clr = c;
    v.e_out = eo; v.e_outn = eon; v.e_cnt = ec; v.e_tc = et;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        bit ev;
        if (rst) begin
          m_cnt[d][i] = 0; m_out[d][i] = 0; m_outn[d][i] = 0; m_tc[d][i] = 0; m_inq[d][i] = 0;
          continue;
        end
        ev = (d == 1) ? (in_v[i] && !m_inq[d][i]) : in_v[i];
        m_inq[d][i] = in_v[i];
        m_tc[d][i]  = 0;
        if (clr[i]) begin
          m_cnt[d][i] = 0; m_out[d][i] = 0; m_outn[d][i] = 1;
        end else if (en) begin
          case (mode)
            2'd0: m_out[d][i] = m_out[d][i] ^ ev;
            2'd1: m_out[d][i] = m_out[d][i] ^ !ev;
            2'd2: if (ev) begin
                    m_cnt[d][i] = (m_cnt[d][i] + 1) % M;
                    m_tc[d][i]  = (m_cnt[d][i] == 0);
                  end
            default: if (ev && m_cnt[d][i] > 0) begin
                    m_cnt[d][i] = m_cnt[d][i] - 1;
                    m_tc[d][i]  = (m_cnt[d][i] == 0);
                  end
          endcase
          if (mode >= 2'd2) m_out[d][i] = m_cnt[d][i][0];
          m_outn[d][i] = !m_out[d][i];
        end
      end
    end
  endtask

  task automatic model_check(string tag);
    logic [CH-1:0]    eo [2];
    logic [CH-1:0]    en_ [2];
    logic [CH-1:0]    et [2];
    logic [CH*CW-1:0] ec [2];
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        eo[d][i]            = m_out[d][i];
        en_[d][i]           = m_outn[d][i];
        et[d][i]            = m_tc[d][i];
        ec[d][i*CW +: CW]   = CW'(m_cnt[d][i]);
      end
    end
    check({tag, " lvl out"},  32'(out0),  32'(eo[0]));
    check({tag, " lvl outn"}, 32'(outn0), 32'(en_[0]));
    check({tag, " lvl cnt"},  32'(cnt0),  32'(ec[0]));
    check({tag, " lvl tc"},   32'(tc0),   32'(et[0]));
    check({tag, " edg out"},  32'(out1),  32'(eo[1]));
    check({tag, " edg outn"}, 32'(outn1), 32'(en_[1]));
    check({tag, " edg cnt"},  32'(cnt1),  32'(ec[1]));
    check({tag, " edg tc"},   32'(tc1),   32'(et[1]));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_step();
    #1;
    model_check(tag);
  endtask

  task automatic drive(logic r, logic e, logic [1:0] md, logic [3:0] iv, logic [3:0] c);
    rst = r; en = e; mode = md; in_v = iv; clr = c;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);

    // Directed vectors for the level-event instance.
    tv.push_back(mk(1, 0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0));
    tv.push_back(mk(1, 0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0, 0, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 4'h0));
    tv.push_back(mk(0, 1, 2'd0, 4'h5, 4'h0, 4'h5, 4'hA, 12'h000, 4'h0));
    tv.push_back(mk(0, 1, 2'd0, 4'h5, 4'h0, 4'h0, 4'hF, 12'h000, 4'h0));
    tv.push_back(mk(0, 1, 2'd0, 4'h5, 4'h0, 4'h5, 4'hA, 12'h000, 4'h0));
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] o;
      o = 4'((k % 8) & 1);
      tv.push_back(mk(0, 1, 2'd2, 4'h1, 4'h0, o, ~o, 12'(k % 8), (k == 8) ? 4'h1 : 4'h0));
    end
    tv.push_back(mk(0, 1, 2'd2, 4'h2, 4'h0, 4'h2, 4'hD, 12'h008, 4'h0));
    tv.push_back(mk(0, 1, 2'd2, 4'h2, 4'h0, 4'h0, 4'hF, 12'h010, 4'h0));
    tv.push_back(mk(0, 1, 2'd3, 4'h2, 4'h0, 4'h2, 4'hD, 12'h008, 4'h0));
    tv.push_back(mk(0, 1, 2'd3, 4'h2, 4'h0, 4'h0, 4'hF, 12'h000, 4'h2));
    tv.push_back(mk(0, 1, 2'd3, 4'h2, 4'h0, 4'h0, 4'hF, 12'h000, 4'h0));
    tv.push_back(mk(0, 1, 2'd3, 4'h2, 4'h0, 4'h0, 4'hF, 12'h000, 4'h0));

    for (int j = 0; j < tv.size(); j++) begin
      drive(tv[j].rst, tv[j].en, tv[j].mode, tv[j].in, tv[j].clr);
      step($sformatf("vec%0d", j));
      check($sformatf("vec%0d tbl out", j),  32'(out0),  32'(tv[j].e_out));
      check($sformatf("vec%0d tbl outn", j), 32'(outn0), 32'(tv[j].e_outn));
      check($sformatf("vec%0d tbl cnt", j),  32'(cnt0),  32'(tv[j].e_cnt));
      check($sformatf("vec%0d tbl tc", j),   32'(tc0),   32'(tv[j].e_tc));
    end

    // Rising-edge counting: high 5 cycles, low 1, high again.
    drive(0, 1, 2'd2, 4'h0, 4'hF);
    step("edge clr");
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 2'd2, 4'h4, 4'h0);
      step("edge hi");
    end
    check("edge cnt2 after hold", 32'(cnt1[2*CW +: CW]), 32'd1);
    drive(0, 1, 2'd2, 4'h0, 4'h0);
    step("edge lo");
    drive(0, 1, 2'd2, 4'h4, 4'h0);
    step("edge hi2");
    check("edge cnt2 total", 32'(cnt1[2*CW +: CW]), 32'd2);
    check("level cnt2 total", 32'(cnt0[2*CW +: CW]), 32'd6);

    // Clear beats enable on one lane while the others keep counting.
    drive(0, 1, 2'd2, 4'h0, 4'hF);
    step("prio clr all");
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2'd2, 4'hF, 4'h0);
      step("prio count");
    end
    drive(0, 1, 2'd2, 4'hF, 4'h8);
    step("prio clr3");
    check("prio cnt", 32'(cnt0), 32'h124);
    check("prio out", 32'(out0), 32'h0);
    check("prio outn", 32'(outn0), 32'hF);
    check("prio tc", 32'(tc0), 32'h0);

    // Reset lands on the cycle that would otherwise wrap lanes 0..2.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2'd2, 4'hF, 4'h0);
      step("wrap pre");
    end
    check("wrap pre cnt0", 32'(cnt0[CW-1:0]), 32'd7);
    drive(1, 1, 2'd2, 4'hF, 4'h0);
    step("wrap rst");
    check("wrap rst tc", 32'(tc0), 32'h0);
    check("wrap rst cnt", 32'(cnt0), 32'h0);
    check("wrap rst outn", 32'(outn0), 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      r = $urandom;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 2'(r[1:0]),
            4'(r[7:4]), 4'($urandom & $urandom & $urandom));
      step($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
